// File: rtl/execute_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// execute_types
//   Shared types and constants for the riscv64 execute-stage scheduler.
//   - XLEN          : default datapath width
//   - op_class_e    : 2-bit issue-op class (ALU / MUL / DIV / reserved)
//   - sched_state_e : scheduler FSM states
// -----------------------------------------------------------------------------
package execute_types;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    OP_ALU  = 2'b00,
    OP_MUL  = 2'b01,
    OP_DIV  = 2'b10,
    OP_RSVD = 2'b11
  } op_class_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_MUL_WAIT = 2'b01,
    S_DIV_WAIT = 2'b10
  } sched_state_e;

endpackage

// File: rtl/execute_scheduler_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk   - clock, rising edge
//     rst   - asynchronous active-high reset, clears the count
//     inc   - increment request for this cycle
//     count - current count value
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/execute_scheduler.sv
// -----------------------------------------------------------------------------
// execute_scheduler
//   Sequencing controller for the riscv64 execute stage. Accepts one issued op
//   per cycle, classifies it (ALU / MUL / DIV / reserved), launches and waits on
//   the multi-cycle units, and registers the selected result into a single
//   output slot drained by the memory stage.
//   Ports:
//     clk, rst            - clock / async active-high reset
//     flush               - pipeline flush; kills in-flight unit, empties slot
//     in_valid/in_ready   - issue handshake; in_class, in_rd, alu_result
//     mul_start/mul_kill  - multiplier launch pulse / abort
//     mul_done/mul_result - multiplier completion pulse and result
//     div_*               - same for the divider
//     out_valid/out_ready - output slot handshake; out_rd, out_data, out_illegal
//     busy                - FSM is waiting on a multi-cycle unit
//     stall_cycles        - saturating count of in_valid & !in_ready cycles
// -----------------------------------------------------------------------------
module execute_scheduler #(
  parameter int XLEN        = execute_types::XLEN,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_class,
  input  logic [4:0]             in_rd,
  input  logic [XLEN-1:0]        alu_result,
  output logic                   mul_start,
  output logic                   mul_kill,
  input  logic                   mul_done,
  input  logic [XLEN-1:0]        mul_result,
  output logic                   div_start,
  output logic                   div_kill,
  input  logic                   div_done,
  input  logic [XLEN-1:0]        div_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4:0]             out_rd,
  output logic [XLEN-1:0]        out_data,
  output logic                   out_illegal,
  output logic                   busy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  import execute_types::*;

  sched_state_e    state_q, state_d;
  logic [4:0]      rd_lat_q, rd_lat_d;
  logic            out_valid_q, out_valid_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic            out_illegal_q, out_illegal_d;

  logic            drain;
  logic            accept;
  logic            load;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            ld_illegal;
  logic            mul_start_c, mul_kill_c, div_start_c, div_kill_c;

  assign drain    = out_valid_q & out_ready;
  // The slot is free or draining this cycle, so a WAIT state always starts
  // with the slot empty and the unit result can never collide with it.
  assign in_ready = (state_q == S_IDLE) & (~out_valid_q | drain) & ~flush;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    rd_lat_d    = rd_lat_q;
    load        = 1'b0;
    ld_rd       = '0;
    ld_data     = '0;
    ld_illegal  = 1'b0;
    mul_start_c = 1'b0;
    mul_kill_c  = 1'b0;
    div_start_c = 1'b0;
    div_kill_c  = 1'b0;

    if (flush) begin
      // Flush wins over everything, including a done pulse in the same cycle.
      state_d    = S_IDLE;
      mul_kill_c = (state_q == S_MUL_WAIT);
      div_kill_c = (state_q == S_DIV_WAIT);
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // Done pulses seen here are stale (post-flush) and are dropped.
          if (accept) begin
            unique case (op_class_e'(in_class))
              OP_ALU: begin
                load    = 1'b1;
                ld_rd   = in_rd;
                ld_data = alu_result;
              end
              OP_RSVD: begin
                load       = 1'b1;
                ld_rd      = in_rd;
                ld_illegal = 1'b1;
              end
              OP_MUL: begin
                mul_start_c = 1'b1;
                rd_lat_d    = in_rd;
                state_d     = S_MUL_WAIT;
              end
              OP_DIV: begin
                div_start_c = 1'b1;
                rd_lat_d    = in_rd;
                state_d     = S_DIV_WAIT;
              end
              default: ;
            endcase
          end
        end
        S_MUL_WAIT: begin
          if (mul_done) begin
            load    = 1'b1;
            ld_rd   = rd_lat_q;
            ld_data = mul_result;
            state_d = S_IDLE;
          end
        end
        S_DIV_WAIT: begin
          if (div_done) begin
            load    = 1'b1;
            ld_rd   = rd_lat_q;
            ld_data = div_result;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Contents change only on load, so they stay stable under backpressure.
    out_valid_d   = flush ? 1'b0 : (load | (out_valid_q & ~drain));
    out_rd_d      = load ? ld_rd      : out_rd_q;
    out_data_d    = load ? ld_data    : out_data_q;
    out_illegal_d = load ? ld_illegal : out_illegal_q;
  end

  // NOTE: the slot data is cleared on reset because its reset value is
  // architecturally visible on out_rd/out_data, not just a don't-care.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rd_lat_q      <= '0;
      out_valid_q   <= 1'b0;
      out_rd_q      <= '0;
      out_data_q    <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_lat_q      <= rd_lat_d;
      out_valid_q   <= out_valid_d;
      out_rd_q      <= out_rd_d;
      out_data_q    <= out_data_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  // Start/kill are combinational; hold them low while reset is asserted so a
  // unit held in reset never sees a launch.
  assign mul_start = mul_start_c & ~rst;
  assign mul_kill  = mul_kill_c  & ~rst;
  assign div_start = div_start_c & ~rst;
  assign div_kill  = div_kill_c  & ~rst;

  assign out_valid   = out_valid_q;
  assign out_rd      = out_rd_q;
  assign out_data    = out_data_q;
  assign out_illegal = out_illegal_q;
  assign busy        = (state_q != S_IDLE);

  sat_counter #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (in_valid & ~in_ready),
    .count(stall_cycles)
  );

endmodule

// File: doc/execute_scheduler.md
# execute_scheduler

Sequencing controller for the riscv64 execute stage. Accepts issued ops from decode over a valid/ready handshake and classifies each as single-cycle ALU, multi-cycle MUL, multi-cycle DIV or reserved. Launches the multi-cycle units and holds issue while they run. Registers the selected result into a single output slot drained by the memory stage.

## Interface
Parameters:
- XLEN, 64, datapath width
- STALL_CNT_W, 32, width of stall performance counter

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  pipeline flush from commit/redirect
- in_valid  in  1  issue op present
- in_ready  out  1  scheduler accepts op this cycle
- in_class  in  2  00 ALU, 01 MUL, 10 DIV, 11 reserved
- in_rd  in  5  destination register
- alu_result  in  XLEN  combinational ALU result for current issue op
- mul_start  out  1  one-cycle launch pulse to multiplier
- mul_kill  out  1  abort multiplier
- mul_done  in  1  multiplier result valid (single-cycle pulse)
- mul_result  in  XLEN  multiplier result
- div_start, div_kill, div_done, div_result: same as mul_*, for divider
- out_valid  out  1  output slot occupied
- out_ready  in  1  memory stage accepts slot
- out_rd  out  5  destination register of slot
- out_data  out  XLEN  result of slot
- out_illegal  out  1  slot holds reserved-class op
- busy  out  1  state != IDLE
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with in_valid=1, in_ready=0

## Operation
- States: IDLE, MUL_WAIT, DIV_WAIT.
- drain = out_valid & out_ready.
- in_ready = (state==IDLE) & (!out_valid | drain) & !flush.
- accept = in_valid & in_ready.
- IDLE, accept:
  - ALU: load slot {alu_result, in_rd, illegal=0}.
  - Reserved: load slot {0, in_rd, illegal=1}.
  - MUL: mul_start=1 combinationally this cycle, latch in_rd, go to MUL_WAIT.
  - DIV: same with div_start, go to DIV_WAIT.
- MUL_WAIT: on mul_done, load slot {mul_result, latched rd, 0} and go to IDLE. div_done is ignored in this state. DIV_WAIT is symmetric.
- Done pulses arriving in IDLE are ignored; they are stale after a flush.
- Slot occupancy: out_valid set on load, cleared on drain without a simultaneous load. Drain and load in the same cycle keep out_valid=1 with the new contents.
- The slot is always empty during WAIT states, because accept requires the slot free or draining.
- Flush has highest priority:
  - out_valid←0.
  - In MUL_WAIT, mul_kill=1 for that cycle; in DIV_WAIT, div_kill=1.
  - state←IDLE; no accept that cycle.
  - A done pulse coinciding with flush is discarded.
- stall_cycles increments when in_valid & !in_ready and saturates at all-ones. It is not cleared by flush.

## Timing
- Reset values: state IDLE, out_valid 0, out_rd 0, out_data 0, out_illegal 0, stall_cycles 0, busy 0.
- Reset forces all start/kill outputs to 0.
- ALU/reserved latency: accept in cycle N, out_valid=1 in N+1.
- Throughput is 1 op/cycle when out_ready=1.
- MUL/DIV: start in cycle N (same cycle as accept), mul_done in cycle M>N, out_valid in M+1.
- in_ready is low from N+1 through M; it may return high in M+1 if the slot drains.
- A done in cycle N (the start cycle) is ignored: units have ≥1-cycle latency.
- out_rd, out_data and out_illegal are stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation returns to IDLE immediately and asynchronously. No kill pulse is issued; units are reset by the same rst.

## Structure
- execute_types package gains:
  - op_class_e (ALU/MUL/DIV/RSVD, 2 bits)
  - sched_state_e
  - the XLEN constant.
- One sub-module: sat_counter (parameterised width, inc, async reset), used for stall_cycles.
- Remaining logic is one FSM plus the output-slot register.

## Test plan
- Back-to-back ALU: 3 ops rd=1,2,3, alu_result=0x10,0x20,0x30, out_ready=1 → out_valid cycles N+1..N+3 with matching rd/data; in_ready stays 1.
- MUL: accept rd=7 at N; mul_done at N+4 with 0xDEAD → mul_start pulses only at N; in_ready=0 for N+1..N+4; out_data=0xDEAD, out_rd=7 at N+5; stall_cycles=4 if in_valid held.
- Backpressure: ALU op with out_ready=0 for 3 cycles → slot holds its value; in_ready=0; second op accepted in the cycle out_ready rises.
- Flush in DIV_WAIT: flush at N+2 → div_kill=1 at N+2; IDLE at N+3; a div_done at N+5 produces no out_valid.
- Reserved class: in_class=11, rd=9 → out_illegal=1, out_data=0, out_rd=9 next cycle.
- Async reset mid-MUL_WAIT: rst pulse → busy=0, out_valid=0, stall_cycles=0 before the next clock edge.
